// File: rtl/debounce_defs.sv
// Shared definitions for the tick-qualified debouncer: state encodings and
// the counter width helper.
package debounce_defs;

    typedef enum logic [1:0] {
        ST_ZERO  = 2'b00,
        ST_WAIT1 = 2'b01,
        ST_ONE   = 2'b10,
        ST_WAIT0 = 2'b11
    } state_t;

    function automatic int cnt_w(input int stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage flip-flop synchronizer for asynchronous inputs; all stages clear to 0
// on asynchronous active-low reset.
module sync_ff #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/tick_debouncer.sv
// Debounces one raw input: the synchronized level must hold for STABLE_TICKS
// counted tick strobes before db_level follows it; rise/fall pulse on change.
module tick_debouncer
    import debounce_defs::*;
#(
    parameter int STABLE_TICKS = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sw,
    output logic db_level,
    output logic db_rise,
    output logic db_fall
);

    localparam int CNT_W = cnt_w(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    logic             sw_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sw),
        .q   (sw_s)
    );

    // A tick arriving in the cycle that enters a WAIT state is not counted,
    // since the counter is only loaded on that edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ZERO: begin
                if (sw_s) begin
                    state_d = ST_WAIT1;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WAIT1: begin
                if (!sw_s)                          state_d = ST_ZERO;
                else if (tick && cnt_q == CNT_LAST) state_d = ST_ONE;
                else if (tick)                      cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_ONE: begin
                if (!sw_s) begin
                    state_d = ST_WAIT0;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WAIT0: begin
                if (sw_s)                           state_d = ST_ONE;
                else if (tick && cnt_q == CNT_LAST) state_d = ST_ZERO;
                else if (tick)                      cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_ZERO;
        endcase

        level_d = (state_d == ST_ONE) || (state_d == ST_WAIT0);
        rise_d  = (state_q == ST_WAIT1) && (state_d == ST_ONE);
        fall_d  = (state_q == ST_WAIT0) && (state_d == ST_ZERO);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ZERO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign db_level = level_q;
    assign db_rise  = rise_q;
    assign db_fall  = fall_q;

endmodule

// File: doc/tick_debouncer.md
Name: tick_debouncer

Overview:
- Debounces one raw mechanical input (switch or button) using the sample strobe `tick` from the upstream counter_n stage.
- Brings the raw input into the `clk` domain, then requires it to hold a new level for STABLE_TICKS consecutive ticks before the debounced output changes.
- Produces a debounced level plus one-cycle rise and fall pulses for downstream control logic.

Parameters:
- STABLE_TICKS, 4: consecutive `tick` strobes the synchronized input must hold before the output changes; legal range 1..255.
- SYNC_STAGES, 2: flip-flop depth of the input synchronizer; minimum 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; 0 = in reset.
- tick  input  1  one-cycle sample strobe from counter_n; may be held high continuously.
- sw  input  1  raw asynchronous input.
- db_level  output  1  debounced level.
- db_rise  output  1  one-cycle pulse when db_level goes 0->1.
- db_fall  output  1  one-cycle pulse when db_level goes 1->0.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-low on `rst`.
- Reset state: while rst=0, asynchronously clear all synchronizer flops to 0, state to ZERO, counter to 0, and db_level, db_rise, db_fall to 0.
- Synchronizer: sw passes through SYNC_STAGES flops to give sw_s. With SYNC_STAGES=2, a raw edge is visible in sw_s 2 clk edges later. The FSM uses only sw_s.
- Counter: CNT_W = $clog2(STABLE_TICKS+1) bits, unsigned.
- FSM states: ZERO, WAIT1, ONE, WAIT0.
- ZERO: if sw_s=1, go to WAIT1 and load cnt=STABLE_TICKS.
- WAIT1:
  - sw_s=0 -> ZERO. This has priority over tick in the same cycle.
  - Else on tick with cnt=1 -> ONE.
  - Else on tick -> cnt-1.
  - No tick -> hold.
- ONE: if sw_s=0, go to WAIT0 and load cnt=STABLE_TICKS.
- WAIT0: mirror of WAIT1 with polarities swapped; exits to ZERO on the final tick, or back to ONE if sw_s=1.
- db_level: registered output; 1 in ONE and WAIT0, 0 in ZERO and WAIT1. It changes on the same clk edge as the state change.
- db_rise and db_fall: registered. Each is high for exactly the one cycle after the WAIT1->ONE or WAIT0->ZERO edge, aligned with db_level's new value. They are never high together. Aborted waits (WAIT1->ZERO, WAIT0->ONE) produce no pulse.
- Latency: from a clean raw edge, db_level changes after SYNC_STAGES clk edges plus the STABLE_TICKS-th tick counted in the WAIT state.
  - With tick held high and STABLE_TICKS=4: exactly 2+1+4 = 7 clk edges.
- tick handling: a tick in the same cycle that ZERO/ONE moves into WAIT is not counted.
- Mid-operation reset: takes effect immediately, without waiting for a clk edge, and discards all progress. After release, a level still held on sw requires the full count again.
- Illegal state encodings recover to ZERO on the next clk edge.

Decomposition:
- Shared package/header debounce_defs: 2-bit state encodings ST_ZERO=2'b00, ST_WAIT1=2'b01, ST_ONE=2'b10, ST_WAIT0=2'b11, plus the CNT_W width function/macro.
- One sub-module: sync_ff, a parameterized N-stage synchronizer with the same clk and async active-low rst. Reused elsewhere for other asynchronous inputs.
- The FSM and counter stay in tick_debouncer.

Test Plan:
1. Reset: rst=0 for the first 10 ns with sw=1 and clk period 20 ns -> db_level=0, db_rise=0, db_fall=0 throughout reset. Outputs drop immediately when rst asserts mid-cycle.
2. Clean press: counter_n BITS=3 (tick every 8 clk), STABLE_TICKS=4, sw 0->1 held for 60 clk -> db_level rises on the 4th tick after sw_s=1. Exactly one db_rise pulse, 1 clk wide, and zero db_fall.
3. Bounce: sw high spanning only 3 ticks, then low for 40 clk; repeat 3 times -> db_level stays 0 and no pulses occur.
4. Clean release: from db_level=1, sw 1->0 held -> db_level falls on the 4th tick. Exactly one db_fall and no db_rise.
5. Glitch/tick collision: force sw_s=0 in the same cycle as the final tick while in WAIT1 with cnt=1 -> state ZERO, db_level stays 0, no db_rise.
6. Reset mid-wait plus tick tied high: assert rst after 2 counted ticks in WAIT1, release with sw=1 -> outputs 0 immediately. db_level rises exactly 7 clk edges after release (tick=1 continuously).
